// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet-5 pipeline: sequencer state encodings,
// layer index constants and the default layer count.
package lenet_pkg;

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_RUN     = 5'b00010,
        S_RELEASE = 5'b00100,
        S_GAP     = 5'b01000,
        S_FINISH  = 5'b10000
    } seq_state_t;

    localparam int L1_CONV_POOL = 0;
    localparam int L3_CONV_POOL = 1;
    localparam int L5_FC        = 2;
    localparam int L6_FC        = 3;

    localparam int DEFAULT_NUM_LAYERS = 4;

endpackage

// File: rtl/lenet_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module lenet_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/lenet_layer_sequencer.sv
// Runs the LeNet layer engines one at a time over a level en/done handshake.
// Optional per-layer watchdog: define LAYER_SEQ_WATCHDOG_EN.
module lenet_layer_sequencer
    import lenet_pkg::*;
#(
    parameter int NUM_LAYERS = DEFAULT_NUM_LAYERS,
    parameter int IDX_W      = 2,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 20,
    parameter int WDT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [NUM_LAYERS-1:0] layer_en,
    output logic [IDX_W-1:0]      mem_owner,
    output logic [IDX_W-1:0]      cur_layer,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      cycle_count,
    output logic                  err_timeout
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    seq_state_t       state;
    logic             cur_done;
    logic             last_layer;
    logic             gap_last;
    logic             wdt_hit;
    logic [IDX_W-1:0] next_idx;
    logic [GAP_W-1:0] gap_cnt;

    assign cur_done   = layer_done[cur_layer];
    assign last_layer = (cur_layer == IDX_W'(NUM_LAYERS - 1));
    assign next_idx   = cur_layer + IDX_W'(1);
    assign gap_last   = (gap_cnt == GAP_LAST);

    lenet_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == S_IDLE && start),
        .en    (state inside {S_RUN, S_RELEASE, S_GAP}),
        .count (cycle_count)
    );

    lenet_sat_counter #(.W(GAP_W)) u_gap_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state != S_GAP),
        .en    (state == S_GAP),
        .count (gap_cnt)
    );

`ifdef LAYER_SEQ_WATCHDOG_EN
    localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt;

    // Cleared whenever not in RUN, so every layer gets a fresh budget.
    lenet_sat_counter #(.W(WDT_W)) u_wdt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state != S_RUN),
        .en    (state == S_RUN),
        .count (wdt_cnt)
    );

    assign wdt_hit = (wdt_cnt == WDT_LAST);
`else
    assign wdt_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            layer_en    <= '0;
            cur_layer   <= '0;
            mem_owner   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_RUN;
                        cur_layer   <= '0;
                        mem_owner   <= '0;
                        err_timeout <= 1'b0;
                        layer_en    <= NUM_LAYERS'(1);
                        busy        <= 1'b1;
                    end
                end
                default: begin
                    // abort outranks every other transition out of a busy state
                    if (abort) begin
                        state    <= S_IDLE;
                        layer_en <= '0;
                        busy     <= 1'b0;
                    end else begin
                        case (state)
                            S_RUN: begin
                                if (cur_done) begin
                                    state    <= S_RELEASE;
                                    layer_en <= '0;
                                end else if (wdt_hit) begin
                                    state       <= S_IDLE;
                                    layer_en    <= '0;
                                    busy        <= 1'b0;
                                    err_timeout <= 1'b1;
                                end
                            end
                            S_RELEASE: begin
                                if (!cur_done) begin
                                    if (last_layer) begin
                                        state <= S_FINISH;
                                        done  <= 1'b1;
                                    end else begin
                                        cur_layer <= next_idx;
                                        mem_owner <= next_idx;
                                        if (GAP_CYCLES == 0) begin
                                            state    <= S_RUN;
                                            layer_en <= NUM_LAYERS'(1) << next_idx;
                                        end else begin
                                            state <= S_GAP;
                                        end
                                    end
                                end
                            end
                            S_GAP: begin
                                if (gap_last) begin
                                    state    <= S_RUN;
                                    layer_en <= NUM_LAYERS'(1) << cur_layer;
                                end
                            end
                            S_FINISH: begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lenet_layer_sequencer.sv
// Scoreboard bench for lenet_layer_sequencer: randomized layer responders,
// run outcomes predicted from per-layer latencies and checked by a monitor.
module tb_lenet_layer_sequencer;
    import lenet_pkg::*;

    localparam int NL  = 3;
    localparam int IW  = 2;
    localparam int GAP = 2;
    localparam int CW  = 20;
    localparam int WDT = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a = 1'b1, start_a = 1'b0, abort_a = 1'b0;
    logic [NL-1:0] layer_done_a, layer_en_a;
    logic [IW-1:0] mem_owner_a, cur_layer_a;
    logic          busy_a, done_a, err_a;
    logic [CW-1:0] cycle_count_a;

    logic          rst_b = 1'b1, start_b = 1'b0, abort_b = 1'b0;
    logic [NL-1:0] layer_done_b, layer_en_b;
    logic [IW-1:0] mem_owner_b, cur_layer_b;
    logic          busy_b, done_b, err_b;
    logic [CW-1:0] cycle_count_b;

    lenet_layer_sequencer #(.NUM_LAYERS(NL), .IDX_W(IW), .GAP_CYCLES(GAP), .CNT_W(CW), .WDT_CYCLES(WDT)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .abort(abort_a), .layer_done(layer_done_a),
        .layer_en(layer_en_a), .mem_owner(mem_owner_a), .cur_layer(cur_layer_a), .busy(busy_a),
        .done(done_a), .cycle_count(cycle_count_a), .err_timeout(err_a)
    );

    lenet_layer_sequencer #(.NUM_LAYERS(NL), .IDX_W(IW), .GAP_CYCLES(0), .CNT_W(CW), .WDT_CYCLES(WDT)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .abort(abort_b), .layer_done(layer_done_b),
        .layer_en(layer_en_b), .mem_owner(mem_owner_b), .cur_layer(cur_layer_b), .busy(busy_b),
        .done(done_b), .cycle_count(cycle_count_b), .err_timeout(err_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Layer engine responders: done rises in the lat-th enabled cycle,
    // falls drp+1 cycles after en drops.
    int        lat [2][NL];
    int        drp [2][NL];
    int        cnt [2][NL] = '{default: 0};
    int        off [2][NL] = '{default: 0};
    logic [NL-1:0] rdone [2] = '{default: '0};
    logic [NL-1:0] stale_a = '0;
    bit        hang [NL] = '{default: 1'b0};

    assign layer_done_a = rdone[0] | stale_a;
    assign layer_done_b = rdone[1];

    always @(negedge clk) begin
        logic e;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NL; i++) begin
                e = (d == 0) ? layer_en_a[i] : layer_en_b[i];
                if (e) begin
                    off[d][i] = 0;
                    cnt[d][i]++;
                    if (!(d == 0 && hang[i]) && cnt[d][i] == lat[d][i]) rdone[d][i] = 1'b1;
                end else begin
                    cnt[d][i] = 0;
                    if (rdone[d][i]) begin
                        off[d][i]++;
                        if (off[d][i] > drp[d][i]) begin
                            rdone[d][i] = 1'b0;
                            off[d][i]   = 0;
                        end
                    end
                end
            end
        end
    end

    typedef struct {
        int pulses;
        int cnt;
        int err;
        int layers;
        int owner;
    } exp_t;
    exp_t sbq[$];

    // Monitor: tracks enable order during a run, compares the outcome when busy falls.
    bit            prev_busy = 1'b0;
    logic [NL-1:0] prev_en   = '0;
    int            mon_pulses = 0;
    int            mon_seen   = 0;

    always @(negedge clk) begin
        exp_t x;
        if (rst_a) begin
            prev_busy = 1'b0;
            prev_en   = '0;
        end else begin
            if (busy_a && !prev_busy) begin
                mon_pulses = 0;
                mon_seen   = 0;
            end
            if (busy_a) begin
                if (done_a) mon_pulses++;
                if (layer_en_a != '0 && layer_en_a != prev_en) begin
                    check("en_order", layer_en_a, NL'(1) << mon_seen);
                    check("owner_in_run", mem_owner_a, mon_seen);
                    check("cur_in_run", cur_layer_a, mon_seen);
                    mon_seen++;
                end
            end
            if (prev_busy && !busy_a) begin
                if (sbq.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    x = sbq.pop_front();
                    check("done_pulses", mon_pulses, x.pulses);
                    check("cycle_count", cycle_count_a, x.cnt);
                    check("err_timeout", err_a, x.err);
                    check("layers_run", mon_seen, x.layers);
                    check("owner_hold", mem_owner_a, x.owner);
                    check("cur_hold", cur_layer_a, x.owner);
                    check("idle_en", layer_en_a, 0);
                    check("idle_done", done_a, 0);
                end
            end
            prev_busy = busy_a;
            prev_en   = layer_en_a;
        end
    end

    task automatic wait_en_a(input logic [NL-1:0] v);
        int n = 0;
        while (layer_en_a !== v && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (layer_en_a !== v) check("wait_en_timeout", layer_en_a, v);
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (busy_a !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy_a !== 1'b0) check("wait_idle_timeout", busy_a, 0);
    endtask

    task automatic start_run_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("start_en0", layer_en_a, 1);
        check("start_busy", busy_a, 1);
        check("start_cnt_clr", cycle_count_a, 0);
        check("start_err_clr", err_a, 0);
    endtask

    // mode: 0 nominal, 1 extra starts, 2 abort in layer 1, 3 stale done on layer 1, 4 layer 1 hangs
    task automatic run_a(input int mode, input bit fixed);
        exp_t x;
        int   m, s, full, head;
        for (int i = 0; i < NL; i++) begin
            lat[0][i] = fixed ? 10 : int'($urandom_range(2, 12));
            drp[0][i] = fixed ? 1 : int'($urandom_range(1, 3));
        end
        if (mode == 2) lat[0][1] = $urandom_range(5, 12);
        m = $urandom_range(0, 2);
        s = $urandom_range(0, 2);
        full = GAP * (NL - 1);
        for (int i = 0; i < NL; i++) full += lat[0][i] + drp[0][i] + 1;
        head = lat[0][0] + drp[0][0] + 1 + GAP;
        x = '{pulses: 1, cnt: full, err: 0, layers: NL, owner: NL - 1};
        case (mode)
            2: x = '{pulses: 0, cnt: head + 1 + m, err: 0, layers: 2, owner: 1};
            3: x.cnt = head + 1 + (1 + s) + GAP + lat[0][2] + drp[0][2] + 1;
`ifdef LAYER_SEQ_WATCHDOG_EN
            4: x = '{pulses: 0, cnt: head + WDT, err: 1, layers: 2, owner: 1};
`else
            4: x = '{pulses: 0, cnt: head + 26, err: 0, layers: 2, owner: 1};
`endif
            default: ;
        endcase
        if (mode == 3) stale_a = 3'b010;
        if (mode == 4) hang[L3_CONV_POOL] = 1'b1;
        sbq.push_back(x);
        start_run_a();
        if (mode != 0) wait_en_a(3'b010);
        case (mode)
            1: begin
                start_a = 1'b1; @(negedge clk);
                start_a = 1'b0; @(negedge clk);
                start_a = 1'b1; @(negedge clk);
                start_a = 1'b0;
            end
            2: begin
                repeat (m) @(negedge clk);
                abort_a = 1'b1;
                @(negedge clk);
                abort_a = 1'b0;
                check("abort_en", layer_en_a, 0);
                check("abort_busy", busy_a, 0);
                check("abort_done", done_a, 0);
            end
            3: begin
                @(negedge clk);
                check("stale_one_run", layer_en_a, 0);
                repeat (s) @(negedge clk);
                stale_a = '0;
            end
            4: begin
                repeat (25) @(negedge clk);
`ifdef LAYER_SEQ_WATCHDOG_EN
                check("wdt_err", err_a, 1);
                check("wdt_busy", busy_a, 0);
                check("wdt_en", layer_en_a, 0);
`else
                check("hang_err", err_a, 0);
                check("hang_en", layer_en_a, 3'b010);
                check("hang_busy", busy_a, 1);
                abort_a = 1'b1;
                @(negedge clk);
                abort_a = 1'b0;
`endif
            end
            default: ;
        endcase
        wait_idle_a();
        if (mode == 0 && fixed) check("nominal_cnt40", cycle_count_a, 40);
        hang[L3_CONV_POOL] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_b();
        int n = 0;
        int z = 0;
        for (int i = 0; i < NL; i++) begin
            lat[1][i] = 3;
            drp[1][i] = 1;
        end
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("b_start_en0", layer_en_b, 1);
        while (layer_en_b !== '0 && n < 100) begin @(negedge clk); n++; end
        while (layer_en_b !== 3'b010 && z < 100) begin z++; @(negedge clk); end
        check("b_no_gap_cycles", z, 2);
        check("b_owner1", mem_owner_b, 1);
        check("b_cur1", cur_layer_b, 1);
        n = 0;
        while (layer_en_b !== '0 && n < 100) begin @(negedge clk); n++; end
        check("b_in_release_busy", busy_b, 1);
        rst_b = 1'b1;
        @(negedge clk);
        check("b_rst_en", layer_en_b, 0);
        check("b_rst_owner", mem_owner_b, 0);
        check("b_rst_cur", cur_layer_b, 0);
        check("b_rst_busy", busy_b, 0);
        check("b_rst_done", done_b, 0);
        check("b_rst_cnt", cycle_count_b, 0);
        check("b_rst_err", err_b, 0);
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_en", layer_en_a, 0);
        check("rst_owner", mem_owner_a, 0);
        check("rst_cur", cur_layer_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_cnt", cycle_count_a, 0);
        check("rst_err", err_a, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);

        run_a(0, 1'b1);
        for (int r = 0; r < 4; r++) run_a(0, 1'b0);
        run_a(1, 1'b0);
        run_a(2, 1'b0);
        run_a(0, 1'b0);
        run_a(3, 1'b0);
        run_a(4, 1'b0);
        run_a(0, 1'b0);
        test_b();

        repeat (5) @(negedge clk);
        check("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded its time bound");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/lenet_layer_sequencer.md
Name: lenet_layer_sequencer

Overview:
Top-level scheduler for the LeNet-5 pipeline. It runs the layer engines (front conv/pool layer, second conv/pool layer, FC layers) one at a time in fixed order over a level-held en/done handshake. It also drives the select for the shared feature-map block memory port, so only the active layer owns it. It reports overall busy/done and a total cycle count for performance checks.

Parameters:
NUM_LAYERS, 4, number of sequenced layer engines (index 0 runs first)
IDX_W, 2, width of layer index; must satisfy 2**IDX_W >= NUM_LAYERS
GAP_CYCLES, 2, idle cycles between layers while memory ownership switches (0 allowed)
CNT_W, 20, width of cycle_count
WDT_CYCLES, 65535, per-layer timeout limit (only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle request to run the whole network
abort  in  1  level; forces return to IDLE
layer_done  in  NUM_LAYERS  per-layer done level (held high until that layer's en drops)
layer_en  out  NUM_LAYERS  one-hot or zero enable to the layer engines
mem_owner  out  IDX_W  select for the shared feature-map memory port mux
cur_layer  out  IDX_W  index of the layer being sequenced
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when the last layer completes
cycle_count  out  CNT_W  cycles spent in a run, saturating
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset values: state=IDLE; layer_en=0, cur_layer=0, mem_owner=0, busy=0, done=0, cycle_count=0, err_timeout=0. All outputs are registered.
- States (one-hot): IDLE, RUN, RELEASE, GAP, FINISH.
- IDLE:
  - start=1 sampled in cycle T: cur_layer=0, mem_owner=0, cycle_count=0, err_timeout=0; layer_en[0]=1 from T+1 (state RUN).
  - start is ignored in every other state.
- RUN:
  - layer_en[cur_layer]=1; all other bits 0.
  - layer_done[cur_layer]=1 -> RELEASE next cycle, and layer_en drops in that same cycle.
  - Done bits of other layers are ignored.
- RELEASE:
  - layer_en=0. Stay until layer_done[cur_layer]=0, meaning the engine has returned to its own IDLE.
  - On exit, if cur_layer==NUM_LAYERS-1 -> FINISH.
  - Otherwise cur_layer and mem_owner increment by 1 and the state goes to GAP (or directly to RUN when GAP_CYCLES=0).
- GAP: layer_en=0 for exactly GAP_CYCLES cycles, then RUN.
- FINISH: done=1 for one cycle, then IDLE. cur_layer and mem_owner hold their last values until the next start.
- cycle_count:
  - Increments every cycle in RUN, RELEASE and GAP.
  - Saturates at all-ones, holds through FINISH and IDLE, and clears on an accepted start.
- abort=1 in any non-IDLE state: next cycle state=IDLE, layer_en=0, busy=0, no done pulse; cycle_count holds. abort has priority over every other transition.
- rst mid-run returns everything to the reset values in the next cycle, regardless of layer_done.
- A layer_done that is already high on entry to RUN completes that layer after one RUN cycle.

Optional Feature:
LAYER_SEQ_WATCHDOG_EN
- Defined:
  - A per-layer counter clears on RUN entry and increments each RUN cycle.
  - When it reaches WDT_CYCLES without layer_done, err_timeout=1 (sticky until the next accepted start or rst).
  - The state goes to IDLE with layer_en=0 and no done pulse.
- Undefined: no counter is built, err_timeout is tied to 0, and WDT_CYCLES is unused.

Decomposition:
- Shared package lenet_pkg holds:
  - the sequencer state one-hot encodings;
  - the layer index constants (L1_CONV_POOL=0, L3_CONV_POOL=1, L5_FC=2, L6_FC=3);
  - the default NUM_LAYERS.
- One sub-module, lenet_sat_counter (parameterised width, clear/enable, saturating), used for cycle_count, the GAP timer and the watchdog counter.

Test Plan:
- Bench setup: NUM_LAYERS=3, GAP_CYCLES=2. Each responder raises done on its 10th cycle with en high and drops done 1 cycle after en falls.
- Nominal run: start at T -> layer_en[0] high at T+1; en order 001,010,100; mem_owner 0->1->2; single done pulse; cycle_count=40; busy low after done.
- Start ignored while busy: extra start pulses during layer 1 -> no restart, cycle_count=40, exactly one done pulse.
- Abort during layer 1 RUN -> next cycle layer_en=0, busy=0, no done; a new start then runs normally from layer 0.
- Stale done: hold layer_done[1] high before layer 1 is enabled -> layer 0 unaffected; layer 1 completes after 1 RUN cycle; done bits of other layers never advance the sequence.
- Watchdog (macro defined, WDT_CYCLES=20): layer 1 responder never asserts done -> err_timeout=1 after 20 RUN cycles, state IDLE, no done pulse. Without the macro, the same stimulus hangs in RUN with err_timeout=0.
- GAP_CYCLES=0 plus rst mid-run: layer_en moves from layer 0 to layer 1 directly after RELEASE; rst asserted in RELEASE -> all outputs equal the reset values next cycle.
